// File: rtl/super_sample_packer.sv
// Serial-to-parallel packer: gathers SUPER_RATIO samples into one wide word for the FIR input.
// Define PACK_FLUSH_EN to add s_flush (close a partial word early) and m_lanes (valid-lane count).
module super_sample_packer #(
    parameter int SUPER_RATIO = 4,
    parameter int DW          = 32
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [DW-1:0]                       s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
`ifdef PACK_FLUSH_EN
    input  logic                                s_flush,
    output logic [$clog2(SUPER_RATIO+1)-1:0]    m_lanes,
`endif
    output logic [DW*SUPER_RATIO-1:0]           m_data,
    output logic                                m_valid,
    input  logic                                m_ready
);

    localparam int IW = $clog2(SUPER_RATIO);
    localparam logic [IW-1:0] LAST = IW'(SUPER_RATIO - 1);

    logic [SUPER_RATIO-2:0][DW-1:0] acc_q, acc_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [SUPER_RATIO-1:0][DW-1:0] word;
    logic [DW*SUPER_RATIO-1:0]      m_data_q, m_data_d;
    logic                           m_valid_q, m_valid_d;
    logic                           flush_w;
    logic                           completing;
    logic                           in_xfer;

`ifdef PACK_FLUSH_EN
    localparam int LW = $clog2(SUPER_RATIO + 1);
    logic [LW-1:0] lanes_q, lanes_d;
    assign flush_w = s_flush;
    assign m_lanes = lanes_q;
`else
    assign flush_w = 1'b0;
`endif

    assign completing = (idx_q == LAST) || flush_w;
    assign s_ready    = !completing || !m_valid_q || m_ready;
    assign in_xfer    = s_valid && s_ready;
    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;

    // Lanes above the current index are zeroed so stale accumulator contents never leak.
    always_comb begin
        word = '0;
        for (int j = 0; j < SUPER_RATIO - 1; j++) begin
            if (IW'(j) < idx_q) begin
                word[j] = acc_q[j];
            end else if (IW'(j) == idx_q) begin
                word[j] = s_data;
            end
        end
        if (idx_q == LAST) begin
            word[SUPER_RATIO-1] = s_data;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        idx_d     = idx_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
`ifdef PACK_FLUSH_EN
        lanes_d   = lanes_q;
`endif
        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
        if (in_xfer) begin
            if (completing) begin
                m_data_d  = word;
                m_valid_d = 1'b1;
                idx_d     = '0;
`ifdef PACK_FLUSH_EN
                lanes_d   = LW'(idx_q) + LW'(1);
`endif
            end else begin
                for (int j = 0; j < SUPER_RATIO - 1; j++) begin
                    if (IW'(j) == idx_q) begin
                        acc_d[j] = s_data;
                    end
                end
                idx_d = idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            idx_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
`ifdef PACK_FLUSH_EN
            lanes_q   <= '0;
`endif
        end else begin
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
`ifdef PACK_FLUSH_EN
            lanes_q   <= lanes_d;
`endif
        end
    end

endmodule

// File: tb/tb_super_sample_packer.sv
// Directed and randomized checks of super_sample_packer (SUPER_RATIO=4, DW=32).
module tb_super_sample_packer;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic         s_flush = 1'b0;
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready = 1'b1;
`ifdef PACK_FLUSH_EN
    logic [2:0]   m_lanes;
`endif

    int tests = 0;
    int fails = 0;

    super_sample_packer #(.SUPER_RATIO(4), .DW(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
`ifdef PACK_FLUSH_EN
        .s_flush (s_flush),
        .m_lanes (m_lanes),
`endif
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        #1;
        step();
    endtask

    function automatic logic [127:0] w(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    logic [31:0]  q[$];
    logic [127:0] exp_w;

    initial begin
        // Reset state
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_m_valid", 128'(m_valid), 128'd0);
        check("rst_m_data", m_data, 128'd0);
        check("rst_s_ready", 128'(s_ready), 128'd1);

        // Single word 1..4, latency one cycle after last sample
        for (int i = 1; i <= 4; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            #1;
            check("w1_s_ready", 128'(s_ready), 128'd1);
            step();
            if (i < 4) check("w1_not_yet", 128'(m_valid), 128'd0);
        end
        s_valid = 1'b0;
        check("w1_m_valid", 128'(m_valid), 128'd1);
        check("w1_m_data", m_data, w(1, 2, 3, 4));
        step();
        check("w1_drained", 128'(m_valid), 128'd0);

        // Continuous stream 1..16 with no stalls
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            #1;
            check("str_s_ready", 128'(s_ready), 128'd1);
            step();
            if (i % 4 == 0) begin
                check("str_m_valid", 128'(m_valid), 128'd1);
                check("str_m_data", m_data, w(32'(i-3), 32'(i-2), 32'(i-1), 32'(i)));
            end else begin
                check("str_gap", 128'(m_valid), 128'd0);
            end
        end
        s_valid = 1'b0;
        step();

        // Backpressure: m_ready low, feed 1..8
        m_ready = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            send(32'(i));
            if (i >= 4) begin
                check("bp_hold_valid", 128'(m_valid), 128'd1);
                check("bp_hold_data", m_data, w(1, 2, 3, 4));
            end
        end
        s_valid = 1'b1;
        s_data  = 32'd8;
        #1;
        check("bp_full_s_ready", 128'(s_ready), 128'd0);
        step();
        check("bp_stall_data", m_data, w(1, 2, 3, 4));
        check("bp_stall_s_ready", 128'(s_ready), 128'd0);
        m_ready = 1'b1;
        #1;
        check("bp_release_s_ready", 128'(s_ready), 128'd1);
        step();
        s_valid = 1'b0;
        check("bp_swap_valid", 128'(m_valid), 128'd1);
        check("bp_swap_data", m_data, w(5, 6, 7, 8));
        step();
        check("bp_drained", 128'(m_valid), 128'd0);

        // Reset mid-operation with a pending word and a partial word
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(32'(i));
        send(32'd9);
        send(32'd10);
        s_valid = 1'b0;
        check("pre_rst_valid", 128'(m_valid), 128'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 128'(m_valid), 128'd0);
        check("mid_rst_data", m_data, 128'd0);
        step();
        reset   = 1'b0;
        m_ready = 1'b1;
        for (int i = 11; i <= 14; i++) send(32'(i));
        s_valid = 1'b0;
        check("post_rst_valid", 128'(m_valid), 128'd1);
        check("post_rst_data", m_data, w(11, 12, 13, 14));
        step();

`ifdef PACK_FLUSH_EN
        // Flush of a 2-lane and a 1-lane word
        send(32'd5);
        s_flush = 1'b1;
        send(32'd6);
        s_flush = 1'b0;
        s_valid = 1'b0;
        check("fl2_data", m_data, w(5, 6, 0, 0));
        check("fl2_lanes", 128'(m_lanes), 128'd2);
        s_flush = 1'b1;
        send(32'd7);
        s_flush = 1'b0;
        s_valid = 1'b0;
        check("fl1_data", m_data, w(7, 0, 0, 0));
        check("fl1_lanes", 128'(m_lanes), 128'd1);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_flush = 1'b1;
        s_data  = 32'd8;
        #1;
        check("fl_full_s_ready", 128'(s_ready), 128'd0);
        m_ready = 1'b1;
        s_flush = 1'b0;
        s_valid = 1'b0;
        step();
        for (int i = 1; i <= 4; i++) send(32'(i));
        s_valid = 1'b0;
        check("full_lanes", 128'(m_lanes), 128'd4);
        step();
`endif

        // Randomized handshakes over 1000 samples against a FIFO scoreboard
        begin
            int sent = 0;
            int got  = 0;
            int cyc  = 0;
            while (got < 1000 && cyc < 20000) begin
                s_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
                s_data  = $urandom;
                m_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (m_valid && m_ready) begin
                    exp_w = '0;
                    for (int k = 0; k < 4; k++) begin
                        if (q.size() > 0) exp_w[32*k +: 32] = q.pop_front();
                    end
                    check("rnd_word", m_data, exp_w);
                    got += 4;
                end
                if (s_valid && s_ready) begin
                    q.push_back(s_data);
                    sent++;
                end
                step();
                cyc++;
            end
            s_valid = 1'b0;
            m_ready = 1'b1;
            check("rnd_received", 128'(got), 128'd1000);
            check("rnd_queue_empty", 128'(q.size()), 128'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/super_sample_packer.md
# super_sample_packer

Serial-to-parallel packer that feeds the super-sampled FIR datapath. It accepts one DW-bit sample per cycle over a valid/ready stream and packs SUPER_RATIO consecutive samples into one wide word. The wide word is presented on a valid/ready output whose lane layout matches the FIR's wide `din`. It sits between a single-rate sample source and the FIR's parallel input, and provides the buffering and backpressure the FIR's free-running wide port does not.

## Interface
Parameters:
- SUPER_RATIO, 4, samples per output word (≥2)
- DW, 32, sample width in bits

Ports:
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high
- s_data  in  DW  input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  packer can accept `s_data` this cycle
- s_flush  in  1  close current word after this sample (present only with PACK_FLUSH_EN)
- m_data  out  DW*SUPER_RATIO  packed word; lane j = bits [DW*j+DW-1 : DW*j]
- m_valid  out  1  `m_data` holds a complete word
- m_ready  in  1  downstream accepts `m_data` this cycle
- m_lanes  out  $clog2(SUPER_RATIO+1)  count of valid lanes in `m_data` (present only with PACK_FLUSH_EN)

## Operation
- Input transfer: `s_valid && s_ready`. Output transfer: `m_valid && m_ready`.
- State:
  - accumulator `acc` of SUPER_RATIO-1 lanes
  - lane index `idx` in 0..SUPER_RATIO-1
  - output register `m_data`/`m_valid`/`m_lanes`
- Ordering: the first sample accepted after a word boundary goes to lane 0 (oldest sample in the lowest lane). Lane j holds the j-th sample of the word.
- Input transfer with `idx < SUPER_RATIO-1` and no closing flush:
  - `acc[idx] <= s_data`
  - `idx <= idx+1`
- Completing transfer, meaning `idx == SUPER_RATIO-1`, or `s_flush` asserted with the macro compiled in:
  - lanes j<idx take `acc[j]`
  - lane idx takes `s_data`
  - lanes j>idx are forced to 0; stale `acc` contents never leak
  - the word loads into the output register; `m_valid <= 1`; `m_lanes <= idx+1`; `idx <= 0`
- Output register:
  - Clears `m_valid` on an output transfer unless a completing transfer reloads it in the same cycle.
  - Holds `m_data` stable while `m_valid && !m_ready`.
- s_ready (combinational):
  - completing is true when `idx == SUPER_RATIO-1`, or when `s_flush` is high (macro only)
  - `s_ready = !completing || !m_valid || m_ready`
- Full condition: `idx == SUPER_RATIO-1` with `m_valid && !m_ready`. In this case `s_ready` is 0 and the pending sample waits.
- Empty condition: `idx == 0` and `!m_valid`. `s_ready` is 1.
- Reset mid-operation discards any partial word and any pending output word; no partial word is emitted.

## Timing
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `m_lanes` = 0
  - `idx` = 0, `acc` = 0
  - `s_ready` = 1 once reset is deasserted
- Latency: a word whose last sample transfers in cycle N has `m_valid` high from cycle N+1.
- Throughput: with `m_ready` held high, one sample per cycle sustained and one word every SUPER_RATIO cycles, with no bubbles.
- Simultaneous completion and output transfer in the same cycle: the new word replaces the old one; `m_valid` stays 1.
- `s_ready` depends combinationally on `m_ready` (and on `s_flush` when the macro is compiled in). There is no combinational path from `s_data` to `m_data`.

## Configuration
- PACK_FLUSH_EN defined:
  - `s_flush` and `m_lanes` ports exist.
  - A flushed word carries `m_lanes` = idx+1 with upper lanes zero.
  - Flush at idx 0 emits a 1-lane word.
  - Flush at `idx == SUPER_RATIO-1` is identical to normal completion.
- PACK_FLUSH_EN undefined:
  - Both ports are absent; words are always full.
  - `s_ready = (idx != SUPER_RATIO-1) || !m_valid || m_ready`.

## Test plan
- Reset, then feed 1,2,3,4 on consecutive cycles with `m_ready`=1 → `m_valid` in the cycle after 4; `m_data` = {4,3,2,1} (lane0 = 1); `s_ready` stays 1 throughout.
- Stream 1..16 continuously with `m_ready`=1 → four words {4,3,2,1}, {8,7,6,5}, {12,11,10,9}, {16,15,14,13}, each on a separate cycle; no input stalls.
- Hold `m_ready`=0 and feed 1..8 → first word stays stable; `s_ready` drops when `idx`=3 with sample 8 pending. Raise `m_ready` → word {4,3,2,1} transfers and {8,7,6,5} loads in the same cycle.
- Assert reset after samples 9,10 → `m_valid`=0, `m_data`=0. Then feed 11..14 → `m_data` = {14,13,12,11}; 9 and 10 never appear.
- PACK_FLUSH_EN: feed 5,6 with `s_flush` on 6 → `m_data` = {0,0,6,5}, `m_lanes` = 2. Then flush a lone 7 → {0,0,0,7}, `m_lanes` = 1.
- Randomized `s_valid`/`m_ready` over 1000 samples → output lanes reproduce the input order exactly, with no loss or duplication.
